// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: FSM encodings,
// default slice geometry and the total-width helper.
package cla_seq_adder_pkg;

  localparam int CLA_CHUNK_W_DEF    = 4;
  localparam int CLA_NUM_CHUNKS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cla_total_w(input int chunk_w, input int num_chunks);
    return chunk_w * num_chunks;
  endfunction

endpackage

// File: rtl/cla_seq_adder_slice.sv
// cla_slice: combinational CHUNK_W-bit carry-lookahead adder built from per-bit
// generate/propagate, with group g/p and the carry into the MSB exposed.
module cla_slice
  import cla_seq_adder_pkg::*;
#(
  parameter int CHUNK_W = CLA_CHUNK_W_DEF
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               c_in,
  output logic [CHUNK_W-1:0] s,
  output logic               c_out,
  output logic               g_out,
  output logic               p_out,
  output logic               c_msb
);

  logic [CHUNK_W-1:0] w_g;
  logic [CHUNK_W-1:0] w_p;
  logic [CHUNK_W:0]   w_c;

  // Flattened lookahead: carry into bit i is the OR of every generate below it
  // masked by the propagates in between, plus c_in masked by all of them.
  function automatic logic lookahead_carry(
    input logic [CHUNK_W-1:0] g,
    input logic [CHUNK_W-1:0] p,
    input logic               cin,
    input int                 bit_i
  );
    logic v_carry;
    logic v_prod;
    v_carry = 1'b0;
    v_prod  = 1'b1;
    for (int j = bit_i - 1; j >= 0; j--) begin
      v_carry = v_carry | (v_prod & g[j]);
      v_prod  = v_prod & p[j];
    end
    return v_carry | (v_prod & cin);
  endfunction

  assign w_g = a & b;
  assign w_p = a ^ b;

  for (genvar i = 0; i <= CHUNK_W; i++) begin : g_carry
    assign w_c[i] = lookahead_carry(w_g, w_p, c_in, i);
  end

  assign s     = w_p ^ w_c[CHUNK_W-1:0];
  assign g_out = lookahead_carry(w_g, w_p, 1'b0, CHUNK_W);
  assign p_out = &w_p;
  assign c_out = g_out | (p_out & c_in);
  assign c_msb = w_c[CHUNK_W-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder: one lookahead slice is stepped across the operand
// chunks LSB first. Define CLA_SEQ_OVF_EN to add the two's-complement ovf output.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter  int CHUNK_W    = CLA_CHUNK_W_DEF,
  parameter  int NUM_CHUNKS = CLA_NUM_CHUNKS_DEF,
  localparam int TOTAL_W    = cla_total_w(CHUNK_W, NUM_CHUNKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] a,
  input  logic [TOTAL_W-1:0] b,
  input  logic               c_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] sum,
  output logic               c_out,
  output logic               busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int             IDX_W    = $clog2(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [TOTAL_W-1:0] r_a;
  logic [TOTAL_W-1:0] r_b;
  logic [TOTAL_W-1:0] r_sum;
  logic               r_cout;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic [CHUNK_W-1:0] w_a_chunk;
  logic [CHUNK_W-1:0] w_b_chunk;
  logic [CHUNK_W-1:0] w_s;
  logic               w_c_out;
  logic               w_g_out;
  logic               w_p_out;
  logic               w_c_msb;
  logic               w_last;

  assign w_a_chunk = r_a[int'(r_idx) * CHUNK_W +: CHUNK_W];
  assign w_b_chunk = r_b[int'(r_idx) * CHUNK_W +: CHUNK_W];
  assign w_last    = (r_idx == LAST_IDX);

  cla_slice #(
    .CHUNK_W (CHUNK_W)
  ) u_slice (
    .a     (w_a_chunk),
    .b     (w_b_chunk),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_c_out),
    .g_out (w_g_out),
    .p_out (w_p_out),
    .c_msb (w_c_msb)
  );

`ifdef CLA_SEQ_OVF_EN
  logic r_ovf;
  logic w_unused;

  assign w_unused = &{1'b0, w_g_out, w_p_out};
  assign ovf      = r_ovf;

  // Overflow flag: captured on the final chunk, held through DONE, cleared on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_RUN && w_last) begin
      r_ovf <= w_c_msb ^ w_c_out;
    end else if (r_state == ST_DONE && out_ready) begin
      r_ovf <= 1'b0;
    end else if (r_state != ST_RUN && r_state != ST_DONE) begin
      r_ovf <= 1'b0;
    end
  end
`else
  logic w_unused;

  assign w_unused = &{1'b0, w_g_out, w_p_out, w_c_msb};
`endif

  // Control FSM: accept in IDLE, one chunk per RUN cycle, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= c_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[int'(r_idx) * CHUNK_W +: CHUNK_W] <= w_s;
          r_carry <= w_c_out;
          // idx stops at the last chunk so it never wraps; DONE clears it.
          if (w_last) begin
            r_cout      <= w_c_out;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign busy      = r_busy;

endmodule
